// File: rtl/puf_response_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : puf_response_reader_pkg
// Description : Shared types and defaults for the PUF response reader.
//               Provides the sweep FSM state encoding, default parameter
//               values and legality helpers used by the elaboration check.
// Revision    : 1.0 - initial release
// ============================================================================
package puf_response_reader_pkg;

  localparam int DEF_CHAL_W        = 2;
  localparam int DEF_SETTLE_CYCLES = 8;
  localparam int DEF_VOTES         = 5;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  // Majority voting needs an odd sample count so ties cannot happen.
  function automatic bit votes_ok(input int votes);
    return (votes >= 1) && (votes <= 15) && ((votes % 2) == 1);
  endfunction

  // The challenge must be stable long enough to pass the 2-flop synchroniser.
  function automatic bit settle_ok(input int settle_cycles);
    return settle_cycles >= 3;
  endfunction

endpackage
`default_nettype wire

// File: rtl/puf_response_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : puf_response_reader_if
// Description : Consumer-side handshake of the PUF response reader.
//               start         : 1-cycle sweep request (master -> slave)
//               busy          : sweep in progress
//               done          : 1-cycle pulse, results valid from this cycle
//               response      : voted response word, bit i = challenge i
//               unstable_mask : bit i set when challenge i votes disagreed
// Revision    : 1.0 - initial release
// ============================================================================
interface puf_response_reader_if #(
  parameter int NUM_CHAL = 4
) ();

  logic                start;
  logic                busy;
  logic                done;
  logic [NUM_CHAL-1:0] response;
  logic [NUM_CHAL-1:0] unstable_mask;

  modport master (
    output start,
    input  busy,
    input  done,
    input  response,
    input  unstable_mask
  );

  modport slave (
    input  start,
    output busy,
    output done,
    output response,
    output unstable_mask
  );

endinterface
`default_nettype wire

// File: rtl/puf_response_reader_sync.sv
`default_nettype none
// ============================================================================
// Module      : puf_sync_2ff
// Description : Two-flop synchroniser for the asynchronous PUF output.
//               clk : sampling clock
//               rst : synchronous active-high reset, both flops clear to 0
//               d   : asynchronous input
//               q   : synchronised output (2-cycle latency)
// Revision    : 1.0 - initial release
// ============================================================================
module puf_sync_2ff (
  input  wire  clk,
  input  wire  rst,
  input  wire  d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule
`default_nettype wire

// File: rtl/puf_response_reader.sv
`default_nettype none
// ============================================================================
// Module      : puf_response_reader
// Description : Sweeps every challenge of an arbiter PUF, holds each one for
//               SETTLE_CYCLES, majority-votes VOTES synchronised samples and
//               publishes the full response word with a one-cycle done pulse.
//               clk           : single clock
//               rst           : synchronous active-high reset
//               bus           : consumer handshake (start/busy/done/
//                               response/unstable_mask), slave side
//               puf_enable    : PUF enable, high while sweeping
//               puf_challenge : challenge driven to the PUF
//               puf_response  : asynchronous PUF output bit
// Revision    : 1.0 - initial release
// ============================================================================
module puf_response_reader
  import puf_response_reader_pkg::*;
#(
  parameter int CHAL_W        = DEF_CHAL_W,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int VOTES         = DEF_VOTES
) (
  input  wire                      clk,
  input  wire                      rst,
  puf_response_reader_if.slave     bus,
  output logic                     puf_enable,
  output logic [CHAL_W-1:0]        puf_challenge,
  input  wire                      puf_response
);

  localparam int NUM_CHAL = 1 << CHAL_W;
  localparam int CNT_W    = $clog2(VOTES + 1);
  localparam int SET_W    = $clog2(SETTLE_CYCLES + 1);

  // Refuse to build with parameters that would break voting or sync timing.
  if (!votes_ok(VOTES) || !settle_ok(SETTLE_CYCLES)) begin : g_param_check
    $fatal(1, "puf_response_reader: VOTES must be odd in 1..15 and SETTLE_CYCLES >= 3");
  end

  state_t              state,        state_nx;
  logic [CHAL_W-1:0]   chal,         chal_nx;
  logic [SET_W-1:0]    settle_cnt,   settle_nx;
  logic [CNT_W-1:0]    vote_cnt,     vote_nx;
  logic [CNT_W-1:0]    ones_cnt,     ones_nx;
  logic [NUM_CHAL-1:0] shadow_resp,  shadow_resp_nx;
  logic [NUM_CHAL-1:0] shadow_unst,  shadow_unst_nx;
  logic [NUM_CHAL-1:0] resp_q,       resp_nx;
  logic [NUM_CHAL-1:0] unst_q,       unst_nx;

  logic                sync_bit;
  logic [CNT_W-1:0]    ones_total;
  logic                vote_bit;
  logic                vote_unst;

  puf_sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (puf_response),
    .q   (sync_bit)
  );

  // Outputs are plain decodes of registered state, so they are glitch-free
  // and line up exactly with the state they describe.
  assign bus.busy          = (state == S_SETTLE) || (state == S_SAMPLE);
  assign bus.done          = (state == S_FINISH);
  assign bus.response      = resp_q;
  assign bus.unstable_mask = unst_q;
  assign puf_enable        = (state == S_SETTLE) || (state == S_SAMPLE);
  assign puf_challenge     = chal;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      chal        <= '0;
      settle_cnt  <= '0;
      vote_cnt    <= '0;
      ones_cnt    <= '0;
      shadow_resp <= '0;
      shadow_unst <= '0;
      resp_q      <= '0;
      unst_q      <= '0;
    end else begin
      state       <= state_nx;
      chal        <= chal_nx;
      settle_cnt  <= settle_nx;
      vote_cnt    <= vote_nx;
      ones_cnt    <= ones_nx;
      shadow_resp <= shadow_resp_nx;
      shadow_unst <= shadow_unst_nx;
      resp_q      <= resp_nx;
      unst_q      <= unst_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    chal_nx        = chal;
    settle_nx      = settle_cnt;
    vote_nx        = vote_cnt;
    ones_nx        = ones_cnt;
    shadow_resp_nx = shadow_resp;
    shadow_unst_nx = shadow_unst;
    resp_nx        = resp_q;
    unst_nx        = unst_q;

    // Vote includes the sample taken in the current cycle, so the decision
    // is ready on the edge that ends the last sample cycle.
    ones_total = ones_cnt + CNT_W'(sync_bit);
    vote_bit   = ones_total > CNT_W'(VOTES / 2);
    vote_unst  = (ones_total != '0) && (ones_total != CNT_W'(VOTES));

    case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_nx       = S_SETTLE;
          chal_nx        = '0;
          settle_nx      = '0;
          vote_nx        = '0;
          ones_nx        = '0;
          shadow_resp_nx = '0;
          shadow_unst_nx = '0;
        end
      end

      S_SETTLE: begin
        if (settle_cnt == SET_W'(SETTLE_CYCLES - 1)) begin
          state_nx  = S_SAMPLE;
          settle_nx = '0;
        end else begin
          settle_nx = settle_cnt + 1'b1;
        end
      end

      S_SAMPLE: begin
        ones_nx = ones_total;
        if (vote_cnt == CNT_W'(VOTES - 1)) begin
          shadow_resp_nx[chal] = vote_bit;
          shadow_unst_nx[chal] = vote_unst;
          vote_nx              = '0;
          ones_nx              = '0;
          if (chal == {CHAL_W{1'b1}}) begin
            // Publish the complete word in one step so consumers never see
            // a partially updated response.
            state_nx = S_FINISH;
            chal_nx  = '0;
            resp_nx  = shadow_resp_nx;
            unst_nx  = shadow_unst_nx;
          end else begin
            state_nx = S_SETTLE;
            chal_nx  = chal + 1'b1;
          end
        end else begin
          vote_nx = vote_cnt + 1'b1;
        end
      end

      S_FINISH: begin
        state_nx = S_IDLE;
      end

      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_puf_response_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_puf_response_reader
// Description : Self-checking bench for puf_response_reader. Two instances:
//               default parameters (A) and CHAL_W=3/VOTES=1/SETTLE=3 (B).
//               A behavioural PUF drives each instance; expected results
//               come from a table-based majority model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_puf_response_reader;

  localparam int SET_A = 8;
  localparam int VOT_A = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- DUT A (defaults) ----------------
  puf_response_reader_if #(.NUM_CHAL(4)) bus_a ();
  logic       en_a;
  logic [1:0] chal_a;
  logic       pin_a = 1'b0;

  puf_response_reader #(.CHAL_W(2), .SETTLE_CYCLES(SET_A), .VOTES(VOT_A)) dut_a (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus_a),
    .puf_enable    (en_a),
    .puf_challenge (chal_a),
    .puf_response  (pin_a)
  );

  // ---------------- DUT B (small parameters) ----------------
  puf_response_reader_if #(.NUM_CHAL(8)) bus_b ();
  logic       en_b;
  logic [2:0] chal_b;
  logic       pin_b = 1'b0;

  puf_response_reader #(.CHAL_W(3), .SETTLE_CYCLES(3), .VOTES(1)) dut_b (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus_b),
    .puf_enable    (en_b),
    .puf_challenge (chal_b),
    .puf_response  (pin_b)
  );

  // ---------------- behavioural PUF models ----------------
  logic [3:0]       tbl_a   = 4'b0;
  logic [3:0]       noisy_a = 4'b0;
  logic [VOT_A-1:0] noise_a [4];
  logic [7:0]       tbl_b   = 8'b0;
  logic             noise_b = 1'b0;

  int         hold_a = 0;
  int         k_a;
  logic       last_en_a = 1'b0;
  logic [1:0] last_chal_a = 2'b0;

  // hold_a counts cycles the current challenge has been presented. Sample k
  // sees the value driven 2 cycles earlier (2-flop sync), so the noisy
  // pattern is laid out at hold cycles SET_A-2 .. SET_A-2+VOT_A-1.
  always @(negedge clk) begin
    if (!en_a || !last_en_a || chal_a != last_chal_a) hold_a = 0;
    else hold_a = hold_a + 1;
    last_en_a   = en_a;
    last_chal_a = chal_a;
    k_a = hold_a - (SET_A - 2);
    if (noisy_a[chal_a] && k_a >= 0 && k_a < VOT_A) pin_a = noise_a[chal_a][k_a];
    else pin_a = tbl_a[chal_a];
  end

  always @(negedge clk) begin
    if (noise_b) pin_b = 1'($urandom_range(0, 1));
    else pin_b = tbl_b[chal_b];
  end

  // Reference: per-challenge ones count over the delivered samples decides
  // the majority bit and the unanimity flag.
  function automatic logic [7:0] model_a();
    logic [3:0] r, m;
    int c;
    for (int i = 0; i < 4; i++) begin
      if (noisy_a[i]) c = $countones(noise_a[i]);
      else c = tbl_a[i] ? VOT_A : 0;
      r[i] = (c > VOT_A / 2);
      m[i] = (c != 0) && (c != VOT_A);
    end
    return {m, r};
  endfunction

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start, then follow the sweep until done (bounded). Returns the
  // start->done latency (-1 on timeout), the challenge sequence as nibbles,
  // and whether response stayed at its entry value until done.
  task automatic run_a(input int inject_at, output int lat, output logic [31:0] seq,
                       output int nchal, output logic held);
    int last;
    logic [3:0] ref_r;
    last  = -1;
    seq   = 32'h0;
    nchal = 0;
    lat   = -1;
    held  = 1'b1;
    ref_r = bus_a.response;
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    for (int k = 1; k <= 120; k++) begin
      bus_a.start = (k == inject_at);
      if (en_a && int'(chal_a) != last) begin
        last  = int'(chal_a);
        seq   = (seq << 4) | 32'(chal_a);
        nchal = nchal + 1;
      end
      if (bus_a.done) begin
        lat = k;
        break;
      end
      if (bus_a.response !== ref_r) held = 1'b0;
      tick();
    end
    bus_a.start = 1'b0;
  endtask

  task automatic run_b(output int lat);
    lat = -1;
    bus_b.start = 1'b1;
    tick();
    bus_b.start = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      if (bus_b.done) begin
        lat = k;
        break;
      end
      tick();
    end
  endtask

  // ---------------- directed + randomized sequence ----------------
  int          lat;
  int          nchal;
  logic [31:0] seq;
  logic        held;
  logic [7:0]  exp_a;
  int          extra_done;
  int          extra_busy;

  initial begin
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    for (int i = 0; i < 4; i++) noise_a[i] = '0;

    // Reset state
    rst = 1'b1;
    tick(); tick();
    chk("reset_a", {bus_a.busy, bus_a.done, en_a, chal_a, bus_a.unstable_mask, bus_a.response}, 64'h0);
    chk("reset_b", {bus_b.busy, bus_b.done, en_b, chal_b, bus_b.unstable_mask, bus_b.response}, 64'h0);

    // start coincident with rst is dropped
    bus_a.start = 1'b1;
    tick();
    rst = 1'b0;
    bus_a.start = 1'b0;
    tick();
    chk("rst_wins_busy", {bus_a.busy, en_a}, 64'h0);

    // Stable table {0:1,1:0,2:1,3:1}, extra start at t0+10
    tbl_a = 4'b1101; noisy_a = 4'b0000;
    run_a(10, lat, seq, nchal, held);
    chk("stable_latency", 64'(lat), 64'd53);
    chk("stable_resp", 64'(bus_a.response), 64'h0d);
    chk("stable_mask", 64'(bus_a.unstable_mask), 64'h0);
    chk("chal_seq", {32'(nchal), seq}, {32'd4, 32'h0123});
    chk("finish_outputs", {bus_a.busy, en_a, chal_a}, 64'h0);

    // start in FINISH cycle is ignored: no further busy/done
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    extra_done = 0; extra_busy = 0;
    for (int k = 0; k < 70; k++) begin
      if (bus_a.done) extra_done++;
      if (bus_a.busy) extra_busy++;
      tick();
    end
    chk("ignored_starts", {32'(extra_done), 32'(extra_busy)}, 64'h0);

    // Noise on challenge 2: 1,0,1,0,1
    noisy_a = 4'b0100; noise_a[2] = 5'b10101;
    run_a(-1, lat, seq, nchal, held);
    chk("noise1_resp", {bus_a.unstable_mask, bus_a.response}, {56'h0, 4'b0100, 4'b1101});

    // Noise on challenge 2: 0,1,0,1,0
    tick();
    noise_a[2] = 5'b01010;
    run_a(-1, lat, seq, nchal, held);
    chk("noise2_resp", {bus_a.unstable_mask, bus_a.response}, {56'h0, 4'b0100, 4'b1001});

    // Back-to-back: start in the IDLE cycle right after done
    tick();
    noisy_a = 4'b0000; tbl_a = 4'b0110;
    run_a(-1, lat, seq, nchal, held);
    chk("b2b_latency", 64'(lat), 64'd53);
    chk("b2b_held", 64'(held), 64'h1);
    chk("b2b_resp", {bus_a.unstable_mask, bus_a.response}, {56'h0, 4'b0000, 4'b0110});

    // rst at t0+20 abandons the sweep
    tick();
    tbl_a = 4'b1011;
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    repeat (19) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_outputs", {bus_a.busy, bus_a.done, en_a, chal_a, bus_a.unstable_mask, bus_a.response}, 64'h0);
    tick();
    run_a(-1, lat, seq, nchal, held);
    chk("post_rst_latency", 64'(lat), 64'd53);
    chk("post_rst_resp", 64'(bus_a.response), 64'h0b);

    // Randomized tables and noise patterns
    for (int r = 0; r < 8; r++) begin
      repeat ($urandom_range(1, 3)) tick();
      tbl_a   = 4'($urandom_range(0, 15));
      noisy_a = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) noise_a[i] = 5'($urandom_range(0, 31));
      exp_a = model_a();
      run_a(-1, lat, seq, nchal, held);
      chk("rand_latency", 64'(lat), 64'd53);
      chk("rand_result", {bus_a.unstable_mask, bus_a.response}, 64'(exp_a));
    end

    // Small-parameter instance: stable then fully noisy
    tbl_b = 8'($urandom_range(0, 255));
    run_b(lat);
    chk("b_latency", 64'(lat), 64'd33);
    chk("b_resp", 64'(bus_b.response), 64'(tbl_b));
    chk("b_mask", 64'(bus_b.unstable_mask), 64'h0);
    tick();
    noise_b = 1'b1;
    run_b(lat);
    chk("b_noise_latency", 64'(lat), 64'd33);
    chk("b_noise_mask", 64'(bus_b.unstable_mask), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
